// File: rtl/ball_packet_tx_if.sv
// Purpose: groups the game_controller request/status signals and the I2C byte-engine handshake.
// Latency: none (wiring only).
// Backpressure: the byte stream is held by m_valid until an m_ready or m_nack pulse.
interface ball_packet_tx_if;
    // game_controller side
    logic        ball_send_trigger;
    logic [9:0]  ball_y;
    logic [7:0]  ball_vy;
    logic [1:0]  gravity_counter;
    logic [19:0] ball_speed;
    logic        is_lose;
    logic        ball_send_to_slave;
    logic        is_i2c_master_done;
    logic        tx_error;
    // I2C master byte engine side
    logic        m_valid;
    logic        m_start;
    logic        m_last;
    logic [6:0]  m_addr;
    logic [7:0]  m_data;
    logic        m_ready;
    logic        m_nack;

    // Transmitter view: sources bytes, consumes requests and handshakes
    modport master (
        input  ball_send_trigger, ball_y, ball_vy, gravity_counter, ball_speed, is_lose,
        input  m_ready, m_nack,
        output ball_send_to_slave, is_i2c_master_done, tx_error,
        output m_valid, m_start, m_last, m_addr, m_data
    );

    // Environment view: game_controller plus I2C byte engine
    modport slave (
        output ball_send_trigger, ball_y, ball_vy, gravity_counter, ball_speed, is_lose,
        output m_ready, m_nack,
        input  ball_send_to_slave, is_i2c_master_done, tx_error,
        input  m_valid, m_start, m_last, m_addr, m_data
    );
endinterface

// File: rtl/ball_packet_tx.sv
// Purpose: snapshots ball state on request and streams the 7-byte register frame to the I2C master.
// Latency: trigger -> first m_valid 2 cycles; final m_ready -> is_i2c_master_done 1 cycle.
// Backpressure: each byte is held until m_ready/m_nack; NACK or byte timeout restarts the frame.
module ball_packet_tx #(
    parameter logic [6:0] SLAVE_ADDR   = 7'h42,
    parameter int         SPEED_THRESH = 235000,
    parameter int         MAX_RETRY    = 3,
    parameter int         BYTE_TIMEOUT = 50000,
    parameter int         DONE_HOLD    = 4
) (
    input  logic          clk_25MHZ,
    input  logic          reset,
    ball_packet_tx_if.master bus
);

    localparam int TW = $clog2(BYTE_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int HW = $clog2(DONE_HOLD + 2);

    typedef enum logic [2:0] {IDLE, LATCH, SEND, RETRY, DONE} state_t;

    state_t         state_q;
    logic [2:0]     byte_idx_q;
    logic [TW-1:0]  timeout_q;
    logic [RW-1:0]  retry_q;
    logic [HW-1:0]  hold_q;

    // Snapshot of the ball state taken in LATCH; the frame is built only from these
    logic [9:0]     y_q;
    logic [7:0]     vy_q;
    logic [1:0]     grav_q;
    logic           slow_q;
    logic           lose_q;

    // Registered outputs
    logic           send_to_slave_q;
    logic           done_q;
    logic           tx_error_q;
    logic           m_valid_q;
    logic           m_start_q;
    logic           m_last_q;
    logic [7:0]     m_data_q;

    // Byte idx of the frame: register pointer 0x00 followed by slv_reg0..slv_reg5
    function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                              input logic [9:0] y, input logic [7:0] vy,
                                              input logic [1:0] grav, input logic slow,
                                              input logic lose);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            3'd1:    b = {y[9:8], 6'b0};
            3'd2:    b = y[7:0];
            3'd3:    b = vy;
            3'd4:    b = {6'b0, grav};
            3'd5:    b = {7'b0, slow};
            3'd6:    b = {7'b0, lose};
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Frame sequencer: request capture, byte streaming, retry on NACK/timeout, done hold
    always_ff @(posedge clk_25MHZ or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            byte_idx_q      <= '0;
            timeout_q       <= '0;
            retry_q         <= '0;
            hold_q          <= '0;
            y_q             <= '0;
            vy_q            <= '0;
            grav_q          <= '0;
            slow_q          <= 1'b0;
            lose_q          <= 1'b0;
            send_to_slave_q <= 1'b0;
            done_q          <= 1'b0;
            tx_error_q      <= 1'b0;
            m_valid_q       <= 1'b0;
            m_start_q       <= 1'b0;
            m_last_q        <= 1'b0;
            m_data_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.ball_send_trigger) state_q <= LATCH;
                end
                LATCH: begin
                    y_q             <= bus.ball_y;
                    vy_q            <= bus.ball_vy;
                    grav_q          <= bus.gravity_counter;
                    slow_q          <= (bus.ball_speed >= 20'(SPEED_THRESH));
                    lose_q          <= bus.is_lose;
                    byte_idx_q      <= '0;
                    retry_q         <= '0;
                    timeout_q       <= '0;
                    tx_error_q      <= 1'b0;
                    send_to_slave_q <= 1'b1;
                    m_valid_q       <= 1'b1;
                    m_start_q       <= 1'b1;
                    m_last_q        <= 1'b0;
                    m_data_q        <= 8'h00;
                    state_q         <= SEND;
                end
                SEND: begin
                    // A NACK wins over a simultaneous m_ready; an accepted byte beats the timeout
                    if (bus.m_nack || (!bus.m_ready && timeout_q == TW'(BYTE_TIMEOUT - 1))) begin
                        m_valid_q <= 1'b0;
                        m_start_q <= 1'b0;
                        m_last_q  <= 1'b0;
                        state_q   <= RETRY;
                    end else if (bus.m_ready) begin
                        if (byte_idx_q == 3'd6) begin
                            m_valid_q       <= 1'b0;
                            m_start_q       <= 1'b0;
                            m_last_q        <= 1'b0;
                            send_to_slave_q <= 1'b0;
                            done_q          <= 1'b1;
                            tx_error_q      <= 1'b0;
                            hold_q          <= '0;
                            state_q         <= DONE;
                        end else begin
                            byte_idx_q <= byte_idx_q + 3'd1;
                            m_data_q   <= frame_byte(byte_idx_q + 3'd1, y_q, vy_q, grav_q,
                                                     slow_q, lose_q);
                            m_start_q  <= 1'b0;
                            m_last_q   <= (byte_idx_q == 3'd5);
                            timeout_q  <= '0;
                        end
                    end else begin
                        timeout_q <= timeout_q + 1'b1;
                    end
                end
                RETRY: begin
                    if (retry_q == RW'(MAX_RETRY)) begin
                        send_to_slave_q <= 1'b0;
                        done_q          <= 1'b1;
                        tx_error_q      <= 1'b1;
                        hold_q          <= '0;
                        state_q         <= DONE;
                    end else begin
                        retry_q    <= retry_q + 1'b1;
                        byte_idx_q <= '0;
                        timeout_q  <= '0;
                        m_valid_q  <= 1'b1;
                        m_start_q  <= 1'b1;
                        m_last_q   <= 1'b0;
                        m_data_q   <= 8'h00;
                        state_q    <= SEND;
                    end
                end
                DONE: begin
                    // Hold done for the minimum time, then wait for the request to drop
                    if (hold_q != HW'(DONE_HOLD - 1)) begin
                        hold_q <= hold_q + 1'b1;
                    end else if (!bus.ball_send_trigger) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ball_send_to_slave = send_to_slave_q;
    assign bus.is_i2c_master_done = done_q;
    assign bus.tx_error           = tx_error_q;
    assign bus.m_valid            = m_valid_q;
    assign bus.m_start            = m_start_q;
    assign bus.m_last             = m_last_q;
    assign bus.m_data             = m_data_q;
    assign bus.m_addr             = SLAVE_ADDR;

endmodule

// File: tb/tb_ball_packet_tx.sv
// Purpose: scoreboard bench for ball_packet_tx with an I2C byte-engine responder.
// Latency: checks trigger->m_valid of 2 cycles and last m_ready->done of 1 cycle.
// Backpressure: responder can ACK, NACK once, withhold m_ready, or reset mid-frame.
module tb_ball_packet_tx;

    logic clk;
    logic rst_n;
    int   tests_run = 0;
    int   fails     = 0;

    // {m_start, m_last, m_data}
    logic [9:0] exp_q[$];
    logic [9:0] obs_q[$];

    ball_packet_tx_if bus();

    ball_packet_tx #(.BYTE_TIMEOUT(20)) dut (
        .clk_25MHZ (clk),
        .reset     (rst_n),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    // Reference frame byte with its expected start/last flags
    function automatic logic [9:0] model_byte(input logic [9:0] y, input logic [7:0] vy,
                                              input logic [1:0] g, input logic [19:0] sp,
                                              input logic lose, input int idx);
        logic [7:0] d;
        case (idx)
            1:       d = {y[9:8], 6'b000000};
            2:       d = y[7:0];
            3:       d = vy;
            4:       d = {6'b000000, g};
            5:       d = (sp >= 20'd235000) ? 8'h01 : 8'h00;
            6:       d = {7'b0000000, lose};
            default: d = 8'h00;
        endcase
        return {(idx == 0), (idx == 6), d};
    endfunction

    task automatic push_frame(input logic [9:0] y, input logic [7:0] vy, input logic [1:0] g,
                              input logic [19:0] sp, input logic lose, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(model_byte(y, vy, g, sp, lose, i));
    endtask

    task automatic set_inputs(input logic [9:0] y, input logic [7:0] vy, input logic [1:0] g,
                              input logic [19:0] sp, input logic lose);
        bus.ball_y          = y;
        bus.ball_vy         = vy;
        bus.gravity_counter = g;
        bus.ball_speed      = sp;
        bus.is_lose         = lose;
    endtask

    // Byte-engine responder: records handshaked bytes, returns when done is seen or budget ends
    task automatic run_link(input int nack_byte, input bit no_ready, input int abort_byte,
                            input bit scramble, input int budget,
                            output bit done_seen, output int done_lat, output int first_valid,
                            output int valid_cycles, output int attempts, output int bsts_low);
        int  pos;
        bit  nacked;
        bit  prev_valid;
        int  last_ack;
        pos = 0; nacked = 0; prev_valid = 0; last_ack = -100;
        done_seen = 0; done_lat = -1; first_valid = -1;
        valid_cycles = 0; attempts = 0; bsts_low = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            bus.m_ready = 1'b0;
            bus.m_nack  = 1'b0;
            if (bus.is_i2c_master_done) begin
                done_seen = 1;
                done_lat  = c - last_ack;
                break;
            end
            if (bus.m_valid) begin
                valid_cycles++;
                if (!prev_valid) attempts++;
                if (first_valid < 0) first_valid = c;
                if (!bus.ball_send_to_slave) bsts_low++;
                if (pos == abort_byte) begin
                    obs_q.push_back({bus.m_start, bus.m_last, bus.m_data});
                    rst_n = 1'b0;
                    break;
                end else if (no_ready) begin
                    // hold the byte until the transmitter times out
                end else if (pos == nack_byte && !nacked) begin
                    obs_q.push_back({bus.m_start, bus.m_last, bus.m_data});
                    bus.m_nack = 1'b1;
                    nacked = 1;
                    pos = 0;
                end else begin
                    obs_q.push_back({bus.m_start, bus.m_last, bus.m_data});
                    bus.m_ready = 1'b1;
                    pos++;
                    if (bus.m_last) last_ack = c;
                end
                if (scramble) begin
                    set_inputs(10'($urandom), 8'($urandom), 2'($urandom), 20'($urandom),
                               1'($urandom));
                    bus.ball_send_trigger = 1'($urandom_range(0, 1));
                end
            end
            prev_valid = bus.m_valid;
        end
    endtask

    task automatic test_reset;
        logic [12:0] outs;
        rst_n = 1'b0;
        bus.ball_send_trigger = 1'b0;
        bus.m_ready = 1'b0;
        bus.m_nack  = 1'b0;
        set_inputs('0, '0, '0, '0, 1'b0);
        #50;
        outs = {bus.m_valid, bus.m_start, bus.m_last, bus.m_data, bus.ball_send_to_slave,
                bus.is_i2c_master_done, bus.tx_error};
        tests_run++;
        if (outs !== 13'h0) begin
            fails++; $display("FAIL reset_outputs got=%h want=0000", outs);
        end
        tests_run++;
        if (bus.m_addr !== 7'h42) begin
            fails++; $display("FAIL reset_addr got=%h want=42", bus.m_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_frame;
        bit done_seen; int lat, fv, vc, att, bl, hc;
        logic [9:0] e, o;
        exp_q.push_back({2'b10, 8'h00}); exp_q.push_back({2'b00, 8'h40});
        exp_q.push_back({2'b00, 8'hA5}); exp_q.push_back({2'b00, 8'hFD});
        exp_q.push_back({2'b00, 8'h02}); exp_q.push_back({2'b00, 8'h01});
        exp_q.push_back({2'b01, 8'h00});
        set_inputs(10'h1A5, 8'hFD, 2'd2, 20'd270000, 1'b0);
        bus.ball_send_trigger = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.m_valid !== 1'b0 || bus.ball_send_to_slave !== 1'b0) begin
            fails++; $display("FAIL basic_latch_cycle valid=%b bsts=%b want 0 0",
                              bus.m_valid, bus.ball_send_to_slave);
        end
        run_link(-1, 0, -1, 0, 40, done_seen, lat, fv, vc, att, bl);
        tests_run++;
        if (fv !== 0) begin fails++; $display("FAIL basic_first_valid got=%0d want=0", fv); end
        tests_run++;
        if (done_seen !== 1'b1 || lat !== 1) begin
            fails++; $display("FAIL basic_done_latency seen=%b lat=%0d want 1 1", done_seen, lat);
        end
        tests_run++;
        if (bl !== 0 || bus.ball_send_to_slave !== 1'b0 || bus.tx_error !== 1'b0) begin
            fails++; $display("FAIL basic_status bsts_low=%0d bsts=%b err=%b want 0 0 0",
                              bl, bus.ball_send_to_slave, bus.tx_error);
        end
        tests_run++;
        if (obs_q.size() !== exp_q.size()) begin
            fails++; $display("FAIL basic_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin fails++; $display("FAIL basic_byte got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        bus.ball_send_trigger = 1'b0;
        hc = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.is_i2c_master_done) hc++; else break;
        end
        tests_run++;
        if (hc !== 4) begin fails++; $display("FAIL basic_done_hold got=%0d want=4", hc); end
    endtask

    task automatic test_lose_hold;
        bit done_seen; int lat, fv, vc, att, bl;
        logic [9:0] e, o;
        set_inputs(10'h2C7, 8'h10, 2'd1, 20'd200000, 1'b1);
        push_frame(10'h2C7, 8'h10, 2'd1, 20'd200000, 1'b1, 7);
        @(negedge clk);
        bus.ball_send_trigger = 1'b1;
        run_link(-1, 0, -1, 0, 40, done_seen, lat, fv, vc, att, bl);
        tests_run++;
        if (obs_q.size() !== 7) begin
            fails++; $display("FAIL lose_count got=%0d want=7", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin fails++; $display("FAIL lose_byte got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        repeat (8) @(negedge clk);
        tests_run++;
        if (bus.is_i2c_master_done !== 1'b1) begin
            fails++; $display("FAIL lose_done_held got=%b want=1", bus.is_i2c_master_done);
        end
        bus.ball_send_trigger = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.is_i2c_master_done !== 1'b0) begin
            fails++; $display("FAIL lose_done_release got=%b want=0", bus.is_i2c_master_done);
        end
    endtask

    task automatic test_nack_retry;
        bit done_seen; int lat, fv, vc, att, bl;
        logic [9:0] e, o;
        set_inputs(10'h0F3, 8'h81, 2'd3, 20'd235000, 1'b0);
        push_frame(10'h0F3, 8'h81, 2'd3, 20'd235000, 1'b0, 4);
        push_frame(10'h0F3, 8'h81, 2'd3, 20'd235000, 1'b0, 7);
        @(negedge clk);
        bus.ball_send_trigger = 1'b1;
        run_link(3, 0, -1, 0, 60, done_seen, lat, fv, vc, att, bl);
        bus.ball_send_trigger = 1'b0;
        tests_run++;
        if (done_seen !== 1'b1 || bus.tx_error !== 1'b0 || att !== 2) begin
            fails++; $display("FAIL nack_result done=%b err=%b attempts=%0d want 1 0 2",
                              done_seen, bus.tx_error, att);
        end
        tests_run++;
        if (obs_q.size() !== 11) begin
            fails++; $display("FAIL nack_count got=%0d want=11", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin fails++; $display("FAIL nack_byte got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        repeat (6) @(negedge clk);
    endtask

    task automatic test_timeout_fail;
        bit done_seen; int lat, fv, vc, att, bl;
        set_inputs(10'h111, 8'h22, 2'd0, 20'd5, 1'b0);
        @(negedge clk);
        bus.ball_send_trigger = 1'b1;
        run_link(-1, 1, -1, 0, 200, done_seen, lat, fv, vc, att, bl);
        bus.ball_send_trigger = 1'b0;
        tests_run++;
        if (done_seen !== 1'b1 || bus.tx_error !== 1'b1) begin
            fails++; $display("FAIL timeout_result done=%b err=%b want 1 1",
                              done_seen, bus.tx_error);
        end
        tests_run++;
        if (att !== 4 || vc !== 80) begin
            fails++; $display("FAIL timeout_attempts attempts=%0d valid_cycles=%0d want 4 80",
                              att, vc);
        end
        tests_run++;
        if (obs_q.size() !== 0) begin
            fails++; $display("FAIL timeout_no_bytes got=%0d want=0", obs_q.size());
        end
        obs_q.delete();
        repeat (6) @(negedge clk);
        tests_run++;
        if (bus.tx_error !== 1'b1 || bus.is_i2c_master_done !== 1'b0) begin
            fails++; $display("FAIL timeout_sticky err=%b done=%b want 1 0",
                              bus.tx_error, bus.is_i2c_master_done);
        end
    endtask

    task automatic test_snapshot;
        bit done_seen; int lat, fv, vc, att, bl, extra;
        logic [9:0] e, o;
        set_inputs(10'h35A, 8'h7F, 2'd1, 20'd900000, 1'b1);
        push_frame(10'h35A, 8'h7F, 2'd1, 20'd900000, 1'b1, 7);
        @(negedge clk);
        bus.ball_send_trigger = 1'b1;
        run_link(-1, 0, -1, 1, 40, done_seen, lat, fv, vc, att, bl);
        bus.ball_send_trigger = 1'b1;
        tests_run++;
        if (done_seen !== 1'b1 || att !== 1 || bus.tx_error !== 1'b0) begin
            fails++; $display("FAIL snap_result done=%b attempts=%0d err=%b want 1 1 0",
                              done_seen, att, bus.tx_error);
        end
        tests_run++;
        if (obs_q.size() !== 7) begin
            fails++; $display("FAIL snap_count got=%0d want=7", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin fails++; $display("FAIL snap_byte got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        repeat (6) @(negedge clk);
        bus.ball_send_trigger = 1'b0;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.m_valid) extra++;
        end
        tests_run++;
        if (extra !== 0 || bus.is_i2c_master_done !== 1'b0) begin
            fails++; $display("FAIL snap_no_second_frame valid_cycles=%0d done=%b want 0 0",
                              extra, bus.is_i2c_master_done);
        end
    endtask

    task automatic test_reset_midframe;
        bit done_seen; int lat, fv, vc, att, bl;
        logic [9:0] e, o;
        logic [12:0] outs;
        set_inputs(10'h2B4, 8'hC3, 2'd2, 20'd240000, 1'b0);
        push_frame(10'h2B4, 8'hC3, 2'd2, 20'd240000, 1'b0, 5);
        @(negedge clk);
        bus.ball_send_trigger = 1'b1;
        run_link(-1, 0, 4, 0, 40, done_seen, lat, fv, vc, att, bl);
        bus.ball_send_trigger = 1'b0;
        #1;
        outs = {bus.m_valid, bus.m_start, bus.m_last, bus.m_data, bus.ball_send_to_slave,
                bus.is_i2c_master_done, bus.tx_error};
        tests_run++;
        if (outs !== 13'h0) begin
            fails++; $display("FAIL midreset_outputs got=%h want=0000", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_frame(10'h2B4, 8'hC3, 2'd2, 20'd240000, 1'b0, 7);
        bus.ball_send_trigger = 1'b1;
        run_link(-1, 0, -1, 0, 40, done_seen, lat, fv, vc, att, bl);
        bus.ball_send_trigger = 1'b0;
        tests_run++;
        if (done_seen !== 1'b1 || obs_q.size() !== 12) begin
            fails++; $display("FAIL midreset_resend done=%b bytes=%0d want 1 12",
                              done_seen, obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin fails++; $display("FAIL midreset_byte got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        repeat (6) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_lose_hold();
        test_nack_retry();
        test_timeout_fail();
        test_snapshot();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
